// File: rtl/port_pkg.sv
// Shared types and constants for the two-requester port arbiter.
package port_pkg;

  localparam int PORT_DATA_W = 16;

  // Requester identifiers, also used as the round-robin pointer encoding.
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_t;

  // Two-way round-robin pick: on a tie the pointer decides, otherwise the lone requester wins.
  function automatic logic rr_pick(input logic a_req, input logic b_req, input logic ptr);
    logic id;
    if (a_req && b_req) begin
      id = ptr;
    end else if (b_req) begin
      id = REQ_B;
    end else begin
      id = REQ_A;
    end
    return id;
  endfunction

endpackage

// File: rtl/port_rr_arb.sv
// Two-way round-robin grant with the preference pointer register.
module port_rr_arb
  import port_pkg::*;
(
  input  logic clk,
  input  logic rstb,
  input  logic a_req,
  input  logic b_req,
  input  logic take,
  output logic grant_valid,
  output logic grant_id
);

  // Requester that wins the next tie; always the one not granted last.
  logic ptr;

  assign grant_valid = a_req | b_req;
  assign grant_id    = rr_pick(a_req, b_req, ptr);

  always_ff @(posedge clk) begin
    if (!rstb) begin
      ptr <= REQ_A;
    end else if (take && grant_valid) begin
      ptr <= ~grant_id;
    end
  end

endmodule

// File: rtl/port_arbiter.sv
// Arbitrates two four-phase requesters onto NPORTS 16-bit ports.
// Optional macro PORT_ARBITER_ADDR_CHECK_EN reports out-of-range addresses through err.
module port_arbiter
  import port_pkg::*;
#(
  parameter int NPORTS = 8,
  parameter int ADDR_W = 4
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic                          a_req,
  input  logic                          a_we,
  input  logic [ADDR_W-1:0]             a_addr,
  input  logic [PORT_DATA_W-1:0]        a_wdata,
  output logic                          a_ack,
  output logic [PORT_DATA_W-1:0]        a_rdata,
  output logic                          a_err,
  input  logic                          b_req,
  input  logic                          b_we,
  input  logic [ADDR_W-1:0]             b_addr,
  input  logic [PORT_DATA_W-1:0]        b_wdata,
  output logic                          b_ack,
  output logic [PORT_DATA_W-1:0]        b_rdata,
  output logic                          b_err,
  output logic [NPORTS-1:0]             port_read,
  output logic [NPORTS-1:0]             port_write,
  output logic [PORT_DATA_W-1:0]        port_wdata,
  input  logic [PORT_DATA_W*NPORTS-1:0] port_rdata,
  output state_t                        fsm_state
);

  localparam logic [ADDR_W:0] NPORTS_W = (ADDR_W + 1)'(NPORTS);

  state_t                  state;
  logic                    gnt_q;
  logic                    we_q;
  logic [ADDR_W-1:0]       addr_q;
  logic                    in_range_q;

  logic                    grant_valid;
  logic                    grant_id;
  logic                    take;
  logic                    g_we;
  logic [ADDR_W-1:0]       g_addr;
  logic [PORT_DATA_W-1:0]  g_wdata;
  logic                    g_in_range;
  logic [NPORTS-1:0]       g_dec;
  logic [PORT_DATA_W-1:0]  sel_rdata;
  logic [PORT_DATA_W-1:0]  cap_rdata;
  logic                    cap_err;
  logic                    cur_req;

  assign fsm_state = state;
  assign take      = (state == IDLE);

  port_rr_arb u_rr (
    .clk         (clk),
    .rstb        (rstb),
    .a_req       (a_req),
    .b_req       (b_req),
    .take        (take),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign g_we       = (grant_id == REQ_B) ? b_we    : a_we;
  assign g_addr     = (grant_id == REQ_B) ? b_addr  : a_addr;
  assign g_wdata    = (grant_id == REQ_B) ? b_wdata : a_wdata;
  assign g_in_range = ({1'b0, g_addr} < NPORTS_W);

  // An out-of-range address matches no decode bit, so it never strobes a port.
  always_comb begin
    g_dec = '0;
    for (int k = 0; k < NPORTS; k++) begin
      g_dec[k] = (g_addr == ADDR_W'(k));
    end
  end

  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < NPORTS; k++) begin
      if (addr_q == ADDR_W'(k)) begin
        sel_rdata = port_rdata[PORT_DATA_W*k +: PORT_DATA_W];
      end
    end
  end

  assign cap_rdata = (we_q || !in_range_q) ? '0 : sel_rdata;

`ifdef PORT_ARBITER_ADDR_CHECK_EN
  assign cap_err = !in_range_q;
`else
  assign cap_err = 1'b0;
`endif

  assign cur_req = (gnt_q == REQ_B) ? b_req : a_req;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state      <= IDLE;
      gnt_q      <= REQ_A;
      we_q       <= 1'b0;
      addr_q     <= '0;
      in_range_q <= 1'b0;
      port_read  <= '0;
      port_write <= '0;
      port_wdata <= '0;
      a_ack      <= 1'b0;
      a_rdata    <= '0;
      a_err      <= 1'b0;
      b_ack      <= 1'b0;
      b_rdata    <= '0;
      b_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            gnt_q      <= grant_id;
            we_q       <= g_we;
            addr_q     <= g_addr;
            in_range_q <= g_in_range;
            port_write <= g_we ? g_dec : '0;
            port_read  <= g_we ? '0 : g_dec;
            port_wdata <= g_wdata;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          port_read  <= '0;
          port_write <= '0;
          port_wdata <= '0;
          state      <= CAPTURE;
        end
        CAPTURE: begin
          // Ports are sampled here, one cycle after the strobe, giving them a full cycle to respond.
          if (gnt_q == REQ_B) begin
            b_ack   <= 1'b1;
            b_rdata <= cap_rdata;
            b_err   <= cap_err;
          end else begin
            a_ack   <= 1'b1;
            a_rdata <= cap_rdata;
            a_err   <= cap_err;
          end
          state <= ACK;
        end
        ACK: begin
          if (!cur_req) begin
            a_ack   <= 1'b0;
            a_rdata <= '0;
            a_err   <= 1'b0;
            b_ack   <= 1'b0;
            b_rdata <= '0;
            b_err   <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_port_arbiter.sv
// Directed self-checking bench for port_arbiter (NPORTS=8, ADDR_W=4).
module tb_port_arbiter;
  import port_pkg::*;

  localparam int NP = 8;
  localparam int AW = 4;

  logic            clk;
  logic            rstb;
  logic            a_req, a_we, b_req, b_we;
  logic [AW-1:0]   a_addr, b_addr;
  logic [15:0]     a_wdata, b_wdata;
  logic            a_ack, a_err, b_ack, b_err;
  logic [15:0]     a_rdata, b_rdata;
  logic [NP-1:0]   port_read, port_write;
  logic [15:0]     port_wdata;
  logic [16*NP-1:0] port_rdata;
  state_t          fsm_state;

  logic [15:0]     pdata [NP];

  int total = 0;
  int bad   = 0;

  // Observations filled in by run_txn
  int          obs_strobe_cyc, obs_strobe_n, obs_ack_cyc;
  logic [NP-1:0] obs_rd, obs_wr;
  logic [15:0] obs_wd, obs_rdata, obs_rdata_after;
  logic        obs_err, obs_other, obs_overlap, obs_ack_after;

  port_arbiter #(.NPORTS(NP), .ADDR_W(AW)) dut (
    .clk(clk), .rstb(rstb),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .port_read(port_read), .port_write(port_write), .port_wdata(port_wdata),
    .port_rdata(port_rdata), .fsm_state(fsm_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NP; k++) port_rdata[16*k +: 16] = pdata[k];
  end

  // Driver: issue one request from the current negedge, follow it to ack, then drop req.
  task automatic run_txn(input logic side, input logic we, input logic [AW-1:0] addr,
                         input logic [15:0] wd);
    obs_strobe_cyc = -1; obs_strobe_n = 0; obs_ack_cyc = -1;
    obs_rd = '0; obs_wr = '0; obs_wd = '0; obs_rdata = '0; obs_err = 1'b0;
    obs_other = 1'b0; obs_overlap = 1'b0;
    if (side) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    end
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if ((port_read | port_write) != '0) begin
        obs_strobe_n++;
        if (obs_strobe_cyc < 0) obs_strobe_cyc = c;
        obs_rd = port_read; obs_wr = port_write; obs_wd = port_wdata;
        if ($countones(port_read | port_write) > 1) obs_overlap = 1'b1;
      end
      if (side ? (a_ack || a_err || a_rdata != 16'h0) : (b_ack || b_err || b_rdata != 16'h0))
        obs_other = 1'b1;
      if (side ? b_ack : a_ack) begin
        obs_ack_cyc = c;
        obs_rdata   = side ? b_rdata : a_rdata;
        obs_err     = side ? b_err : a_err;
        break;
      end
    end
    if (side) b_req = 1'b0; else a_req = 1'b0;
    @(negedge clk);
    obs_ack_after   = side ? b_ack : a_ack;
    obs_rdata_after = side ? b_rdata : a_rdata;
  endtask

  task automatic test_reset();
    rstb = 1'b0; a_req = 1'b1; b_req = 1'b1;
    a_we = 1'b1; b_we = 1'b1; a_addr = 4'd1; b_addr = 4'd2;
    a_wdata = 16'hFFFF; b_wdata = 16'hFFFF;
    repeat (3) @(negedge clk);
    total++;
    if (fsm_state !== IDLE) begin
      bad++; $display("FAIL reset_state: got %0d want %0d", fsm_state, IDLE);
    end
    total++;
    if ({port_read, port_write, port_wdata} !== '0) begin
      bad++; $display("FAIL reset_strobes: rd=%h wr=%h wd=%h want 0", port_read, port_write, port_wdata);
    end
    total++;
    if ({a_ack, a_err, a_rdata, b_ack, b_err, b_rdata} !== '0) begin
      bad++; $display("FAIL reset_resp: a=%b/%b/%h b=%b/%b/%h want 0",
                      a_ack, a_err, a_rdata, b_ack, b_err, b_rdata);
    end
    a_req = 1'b0; b_req = 1'b0; rstb = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_a();
    run_txn(1'b0, 1'b0, 4'd3, 16'h5555);
    total++;
    if (obs_rd !== 8'h08 || obs_wr !== 8'h00 || obs_strobe_n != 1 || obs_strobe_cyc != 1) begin
      bad++; $display("FAIL read_a_strobe: rd=%h wr=%h n=%0d cyc=%0d want 08/00/1/1",
                      obs_rd, obs_wr, obs_strobe_n, obs_strobe_cyc);
    end
    total++;
    if (obs_ack_cyc != 3) begin
      bad++; $display("FAIL read_a_latency: ack cycle %0d want 3", obs_ack_cyc);
    end
    total++;
    if (obs_rdata !== 16'hBEEF || obs_err !== 1'b0) begin
      bad++; $display("FAIL read_a_data: rdata=%h err=%b want beef/0", obs_rdata, obs_err);
    end
    total++;
    if (obs_other !== 1'b0) begin
      bad++; $display("FAIL read_a_other: b response active=%b want 0", obs_other);
    end
    total++;
    if (obs_ack_after !== 1'b0 || obs_rdata_after !== 16'h0) begin
      bad++; $display("FAIL read_a_release: ack=%b rdata=%h want 0/0", obs_ack_after, obs_rdata_after);
    end
  endtask

  task automatic test_write_b();
    run_txn(1'b1, 1'b1, 4'd5, 16'h1234);
    total++;
    if (obs_wr !== 8'h20 || obs_rd !== 8'h00 || obs_strobe_n != 1) begin
      bad++; $display("FAIL write_b_strobe: wr=%h rd=%h n=%0d want 20/00/1", obs_wr, obs_rd, obs_strobe_n);
    end
    total++;
    if (obs_wd !== 16'h1234) begin
      bad++; $display("FAIL write_b_wdata: got %h want 1234", obs_wd);
    end
    total++;
    if (obs_ack_cyc != 3 || obs_rdata !== 16'h0 || obs_err !== 1'b0) begin
      bad++; $display("FAIL write_b_ack: cyc=%0d rdata=%h err=%b want 3/0000/0",
                      obs_ack_cyc, obs_rdata, obs_err);
    end
    total++;
    if (obs_other !== 1'b0 || obs_ack_after !== 1'b0) begin
      bad++; $display("FAIL write_b_release: other=%b ack_after=%b want 0/0", obs_other, obs_ack_after);
    end
  endtask

  task automatic test_out_of_range();
    logic exp_err;
`ifdef PORT_ARBITER_ADDR_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    run_txn(1'b0, 1'b0, 4'd9, 16'h0);
    total++;
    if (obs_strobe_n != 0) begin
      bad++; $display("FAIL oor_read_strobe: %0d strobe cycles want 0", obs_strobe_n);
    end
    total++;
    if (obs_ack_cyc != 3 || obs_rdata !== 16'h0 || obs_err !== exp_err) begin
      bad++; $display("FAIL oor_read_ack: cyc=%0d rdata=%h err=%b want 3/0000/%b",
                      obs_ack_cyc, obs_rdata, obs_err, exp_err);
    end
    run_txn(1'b0, 1'b1, 4'd15, 16'hAAAA);
    total++;
    if (obs_strobe_n != 0 || obs_ack_cyc != 3 || obs_err !== exp_err || obs_ack_after !== 1'b0) begin
      bad++; $display("FAIL oor_write: n=%0d cyc=%0d err=%b after=%b want 0/3/%b/0",
                      obs_strobe_n, obs_ack_cyc, obs_err, obs_ack_after, exp_err);
    end
  endtask

  task automatic test_hold();
    int hold_bad = 0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd6; a_wdata = 16'h0;
    @(negedge clk);
    total++;
    if (port_read !== 8'h40) begin
      bad++; $display("FAIL hold_strobe: rd=%h want 40", port_read);
    end
    // Late input changes must not affect the granted transaction
    a_addr = 4'd2; a_we = 1'b1; a_wdata = 16'hFFFF;
    repeat (2) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      if (a_ack !== 1'b1 || a_rdata !== 16'h6006 || fsm_state !== ACK || (port_read | port_write) != '0)
        hold_bad++;
      @(negedge clk);
    end
    total++;
    if (hold_bad != 0) begin
      bad++; $display("FAIL hold_ack: %0d bad cycles, last ack=%b rdata=%h want 1/6006", hold_bad, a_ack, a_rdata);
    end
    a_req = 1'b0;
    @(negedge clk);
    total++;
    if (a_ack !== 1'b0 || a_rdata !== 16'h0 || fsm_state !== IDLE) begin
      bad++; $display("FAIL hold_release: ack=%b rdata=%h state=%0d want 0/0000/0", a_ack, a_rdata, fsm_state);
    end
    a_we = 1'b0;
  endtask

  task automatic test_round_robin();
    logic       order[$];
    logic [3:0] exp_order;
    int         overlap = 0;
    int         both_ack = 0;
    exp_order = 4'b1010;
    rstb = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    for (int r = 0; r < 2; r++) begin
      a_req = 1'b1; a_we = 1'b0; a_addr = AW'(r);
      b_req = 1'b1; b_we = 1'b1; b_addr = AW'(4 + r); b_wdata = 16'h00B0;
      for (int c = 0; c < 40 && (a_req || b_req); c++) begin
        @(negedge clk);
        if ($countones(port_read | port_write) > 1) overlap++;
        if (a_ack && b_ack) both_ack++;
        if (a_ack && a_req) begin order.push_back(REQ_A); a_req = 1'b0; end
        if (b_ack && b_req) begin order.push_back(REQ_B); b_req = 1'b0; end
      end
      a_req = 1'b0; b_req = 1'b0;
      @(negedge clk);
    end
    total++;
    if (order.size() != 4) begin
      bad++; $display("FAIL rr_count: %0d grants want 4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (order[i] !== exp_order[i]) begin
          bad++; $display("FAIL rr_order[%0d]: got %b want %b", i, order[i], exp_order[i]);
        end
      end
    end
    total++;
    if (overlap != 0 || both_ack != 0) begin
      bad++; $display("FAIL rr_exclusive: overlap=%0d both_ack=%0d want 0/0", overlap, both_ack);
    end
  endtask

  task automatic test_mid_reset();
    int late_ack = 0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd3;
    @(negedge clk);
    total++;
    if (port_read !== 8'h08) begin
      bad++; $display("FAIL mid_reset_strobe: rd=%h want 08", port_read);
    end
    @(negedge clk);
    rstb = 1'b0; a_req = 1'b0;
    @(negedge clk);
    total++;
    if (fsm_state !== IDLE || {a_ack, a_err, a_rdata, port_read, port_write, port_wdata} !== '0) begin
      bad++; $display("FAIL mid_reset_clear: state=%0d ack=%b rdata=%h rd=%h want 0",
                      fsm_state, a_ack, a_rdata, port_read);
    end
    rstb = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (a_ack) late_ack++;
    end
    total++;
    if (late_ack != 0) begin
      bad++; $display("FAIL mid_reset_noack: ack seen %0d cycles want 0", late_ack);
    end
    run_txn(1'b0, 1'b0, 4'd1, 16'h0);
    total++;
    if (obs_rd !== 8'h02 || obs_ack_cyc != 3 || obs_rdata !== 16'hA001) begin
      bad++; $display("FAIL mid_reset_after: rd=%h cyc=%0d rdata=%h want 02/3/a001",
                      obs_rd, obs_ack_cyc, obs_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic          side_t [6];
    logic          we_t   [6];
    logic [AW-1:0] addr_t [6];
    logic [NP-1:0] exp_str;
    logic [15:0]   exp_rd;
    side_t = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    we_t   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    addr_t = '{4'd0, 4'd7, 4'd2, 4'd4, 4'd7, 4'd0};
    for (int i = 0; i < 6; i++) begin
      exp_str = NP'(1) << addr_t[i];
      exp_rd  = we_t[i] ? 16'h0 : pdata[addr_t[i]];
      run_txn(side_t[i], we_t[i], addr_t[i], 16'h0C00 + 16'(i));
      total++;
      if ((we_t[i] ? obs_wr : obs_rd) !== exp_str || obs_strobe_n != 1 || obs_ack_cyc != 3
          || obs_rdata !== exp_rd || obs_other !== 1'b0) begin
        bad++; $display("FAIL b2b[%0d]: rd=%h wr=%h n=%0d cyc=%0d rdata=%h other=%b want strobe %h rdata %h",
                        i, obs_rd, obs_wr, obs_strobe_n, obs_ack_cyc, obs_rdata, obs_other, exp_str, exp_rd);
      end
      if (we_t[i]) begin
        total++;
        if (obs_wd !== 16'h0C00 + 16'(i)) begin
          bad++; $display("FAIL b2b_wdata[%0d]: got %h want %h", i, obs_wd, 16'h0C00 + 16'(i));
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NP; k++) pdata[k] = 16'hA000 + 16'(k);
    pdata[3] = 16'hBEEF;
    pdata[6] = 16'h6006;
    rstb = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    @(negedge clk);
    test_reset();
    test_read_a();
    test_write_b();
    test_out_of_range();
    test_hold();
    test_round_robin();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/port_arbiter.md
PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 SHALL have parameter NPORTS, default 8: number of attached 16-bit port instances, range 1..16.
REQ-002 SHALL have parameter ADDR_W, default 4: requester address width, with 2**ADDR_W >= NPORTS.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rstb, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have ports a_req, a_we, input, 1 each: requester A request and write-not-read.
REQ-006 SHALL have ports a_addr, input, ADDR_W; a_wdata, input, 16: requester A port index and write data.
REQ-007 SHALL have ports a_ack, output, 1; a_rdata, output, 16; a_err, output, 1: requester A response.
REQ-008 SHALL have ports b_req, b_we, b_addr, b_wdata, b_ack, b_rdata, b_err: requester B, identical to A.
REQ-009 SHALL have ports port_read and port_write, output, NPORTS each: one-hot per-port strobes.
REQ-010 SHALL have port port_wdata, output, 16: write data broadcast to all ports.
REQ-011 SHALL have port port_rdata, input, 16*NPORTS: concatenated port read data, port k at bits [16k+15:16k].

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS, CAPTURE, ACK.
REQ-013 IDLE: SHALL grant one asserted req at the clock edge, latch its we/addr/wdata, and go to ACCESS.
REQ-014 Both req asserted in IDLE: SHALL grant the requester not granted last (round-robin), with A preferred after reset.
REQ-015 ACCESS, one cycle: SHALL assert port_write[addr] if we=1, otherwise port_read[addr], and drive port_wdata with the latched data.
REQ-016 CAPTURE, one cycle: on a read, SHALL register port_rdata slice [addr] into the granted rdata; on a write, rdata SHALL be 16'h0000.
REQ-017 ACK: SHALL hold granted ack high until granted req is sampled low, then return to IDLE (four-phase handshake).
REQ-018 Latency: req sampled at edge N, strobe in cycle N+1, ack high from cycle N+3.
REQ-019 The non-granted requester's ack, rdata and err SHALL stay 0 throughout; its req SHALL remain pending.
REQ-020 At most one bit of port_read|port_write SHALL be high in any cycle, and only in ACCESS.
REQ-021 rdata and err SHALL be stable while ack is high; both SHALL clear to 0 when ack deasserts.
REQ-022 Changes to the requester inputs after grant SHALL be ignored until the next IDLE.

Reset
REQ-023 rstb=0 at an edge SHALL force IDLE from any state, including mid-transaction, and abandon the transaction without an ack.
REQ-024 Reset values: all strobes 0, port_wdata 0, a_ack/b_ack 0, a_rdata/b_rdata 0, a_err/b_err 0, round-robin pointer = A.

Configuration
REQ-025 With macro PORT_ARBITER_ADDR_CHECK_EN defined: addr >= NPORTS SHALL skip ACCESS strobes, and ACK SHALL set err=1 with rdata=0.
REQ-026 Without PORT_ARBITER_ADDR_CHECK_EN: err SHALL be tied 0, an out-of-range access SHALL produce no strobe, and ACK SHALL return rdata=0; FSM timing SHALL be identical in both builds.

Structure
REQ-027 Package port_pkg SHALL hold the FSM state enum, PORT_DATA_W=16, and the requester ID constants REQ_A/REQ_B.
REQ-028 Sub-module port_rr_arb SHALL contain the 2-way round-robin grant and pointer register; the FSM and muxing SHALL stay in port_arbiter.

Verification
REQ-029 A read, a_addr=3, port 3 data 16'hBEEF: port_read=8'h08 for exactly 1 cycle, a_ack rises 2 cycles after the strobe, a_rdata=16'hBEEF.
REQ-030 B write, b_addr=5, b_wdata=16'h1234: port_write=8'h20 for 1 cycle, port_wdata=16'h1234, b_rdata=0, b_ack held until b_req drops.
REQ-031 A and B request together twice, each dropping req after its ack: grant order A, B, A, B; no overlapping strobes.
REQ-032 rstb low during CAPTURE of an A read: no a_ack, all outputs 0 next cycle; the next request is serviced normally.
REQ-033 A read with a_addr=9, NPORTS=8, macro defined: no strobe, a_err=1, a_rdata=0; macro undefined: no strobe, a_err=0, a_rdata=0.
REQ-034 a_req held high across ack: a_ack stays 1 and no new transaction starts until a_req=0 is sampled.
